// File: rtl/cmd_uart_responder_if.sv
// Command-processor side of the UART responder.
// Carries the assembled command and the response handshake.
interface cmd_uart_responder_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  modport master (
    output clr_cmd_rdy,
    output resp,
    output trmt,
    input  cmd,
    input  cmd_rdy,
    input  tx_done
  );

  modport slave (
    input  clr_cmd_rdy,
    input  resp,
    input  trmt,
    output cmd,
    output cmd_rdy,
    output tx_done
  );
endinterface

// File: rtl/cmd_uart_responder.sv
// Robot-side UART endpoint: two RX bytes form a 16-bit command,
// one response byte goes back out on TX.
module cmd_uart_responder #(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  output logic TX,
  cmd_uart_responder_if.slave bus
);

  localparam int CW = 12;
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_st_t;
  typedef enum logic {B_HIGH, B_LOW} b_st_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_st_t;

  rx_st_t      rx_st;
  b_st_t       b_st;
  tx_st_t      tx_st;

  logic        rx_ff1;
  logic        rx_ff2;
  logic        rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [3:0]  rx_idx;
  logic [7:0]  rx_data;

  logic [15:0] cmd_q;
  logic        rdy_q;

  logic [CW-1:0] tx_cnt;
  logic [3:0]  tx_idx;
  logic [9:0]  tx_sh;
  logic        tx_q;
  logic        done_q;

  logic        start_edge;
  logic        rx_tick;
  logic        stop_hit;
  logic        byte_rdy;
  logic        frame_err;

  assign start_edge = (rx_st == RX_IDLE) && rx_prev && !rx_ff2;
  assign rx_tick    = (rx_st == RX_RECV) && (rx_cnt == ONE);
  assign stop_hit   = rx_tick && (rx_idx == 4'd9);
  assign byte_rdy   = stop_hit && rx_ff2;
  assign frame_err  = stop_hit && !rx_ff2;

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = rdy_q;
  assign bus.tx_done = done_q;
  assign TX          = tx_q;

  // Reset to idle-high so a low pin during reset is not a start edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_data <= '0;
    end else begin
      unique case (rx_st)
        RX_IDLE: begin
          if (start_edge) begin
            rx_cnt <= HALF;
            rx_idx <= '0;
            rx_st  <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (rx_tick) begin
            rx_cnt <= FULL;
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx != 4'd0 && rx_idx != 4'd9)
              rx_data <= {rx_ff2, rx_data[7:1]};
            if (rx_idx == 4'd9)
              rx_st <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - ONE;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // Stop sample completes the byte, so assembly acts on that same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_st  <= B_HIGH;
      cmd_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      if (frame_err) begin
        b_st <= B_HIGH;
      end else if (byte_rdy) begin
        unique case (b_st)
          B_HIGH: begin
            cmd_q[15:8] <= rx_data;
            b_st        <= B_LOW;
          end
          B_LOW: begin
            cmd_q[7:0] <= rx_data;
            b_st       <= B_HIGH;
          end
          default: b_st <= B_HIGH;
        endcase
      end
      if (byte_rdy && b_st == B_LOW)
        rdy_q <= 1'b1;
      else if (bus.clr_cmd_rdy || (start_edge && b_st == B_HIGH))
        rdy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '1;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      unique case (tx_st)
        TX_IDLE: begin
          if (bus.trmt) begin
            tx_sh  <= {1'b1, bus.resp, 1'b0};
            tx_q   <= 1'b0;
            done_q <= 1'b0;
            tx_cnt <= FULL;
            tx_idx <= '0;
            tx_st  <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == ONE) begin
            tx_cnt <= FULL;
            if (tx_idx == 4'd9) begin
              tx_st  <= TX_IDLE;
              done_q <= 1'b1;
              tx_q   <= 1'b1;
            end else begin
              tx_sh  <= {1'b1, tx_sh[9:1]};
              tx_q   <= tx_sh[1];
              tx_idx <= tx_idx + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - ONE;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Bench for cmd_uart_responder: serial stimulus on RX,
// scoreboarded command and TX waveform checks.
module tb_cmd_uart_responder;

  localparam int B = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] cmd_sb[$];
  logic        tx_sb[$];

  cmd_uart_responder_if bus ();

  cmd_uart_responder #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // chk: check cmd_rdy just before and just after the stop sample
  task automatic send_byte(input logic [7:0] d, input logic stop,
                           input logic chk);
    logic [9:0] f;
    logic [15:0] exp;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (i == 9 && chk) begin
        wait_neg(B / 2 + 1);
        n_cmp++;
        if (bus.cmd_rdy !== 1'b0) begin
          n_bad++;
          $display("FAIL rdy_early: got %b want 0", bus.cmd_rdy);
        end
        wait_neg(4);
        exp = cmd_sb.pop_front();
        n_cmp++;
        if (bus.cmd_rdy !== 1'b1) begin
          n_bad++;
          $display("FAIL rdy_set: got %b want 1", bus.cmd_rdy);
        end
        n_cmp++;
        if (bus.cmd !== exp) begin
          n_bad++;
          $display("FAIL cmd: got %h want %h", bus.cmd, exp);
        end
        wait_neg(B - B / 2 - 5);
      end else begin
        wait_neg(B);
      end
    end
  endtask

  task automatic send_cmd(input logic [15:0] c);
    cmd_sb.push_back(c);
    send_byte(c[15:8], 1'b1, 1'b0);
    send_byte(c[7:0], 1'b1, 1'b1);
  endtask

  task automatic run_tx(input logic [7:0] r, input logic busy);
    logic [9:0] f;
    logic e;
    f = {1'b1, r, 1'b0};
    for (int i = 0; i < 10; i++) tx_sb.push_back(f[i]);
    bus.trmt = 1'b1;
    bus.resp = r;
    wait_neg(1);
    bus.trmt = 1'b0;
    bus.resp = 8'($urandom);
    n_cmp++;
    if (tx !== 1'b0 || bus.tx_done !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_start: tx=%b done=%b want 0 0", tx, bus.tx_done);
    end
    wait_neg(B / 2);
    for (int k = 0; k < 10; k++) begin
      e = tx_sb.pop_front();
      n_cmp++;
      if (tx !== e) begin
        n_bad++;
        $display("FAIL tx_bit%0d: got %b want %b", k, tx, e);
      end
      if (busy && k == 3) begin
        bus.trmt = 1'b1;
        bus.resp = 8'h5A;
        wait_neg(1);
        bus.trmt = 1'b0;
        wait_neg(B - 1);
      end else if (k < 9) begin
        wait_neg(B);
      end
    end
    wait_neg(B - B / 2 - 1);
    n_cmp++;
    if (bus.tx_done !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_done_early: got %b want 0", bus.tx_done);
    end
    wait_neg(1);
    n_cmp++;
    if (bus.tx_done !== 1'b1 || tx !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_done: done=%b tx=%b want 1 1", bus.tx_done, tx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_neg(3);
    n_cmp++;
    if ({tx, bus.cmd, bus.cmd_rdy, bus.tx_done} !== {1'b1, 16'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset: tx=%b cmd=%h rdy=%b done=%b want 1 0000 0 0",
               tx, bus.cmd, bus.cmd_rdy, bus.tx_done);
    end
    rst_n = 1'b1;
    wait_neg(4);
  endtask

  task automatic test_cmd_rx;
    send_cmd(16'h7030);
    wait_neg(B);
  endtask

  task automatic test_clear;
    bus.clr_cmd_rdy = 1'b1;
    wait_neg(1);
    bus.clr_cmd_rdy = 1'b0;
    n_cmp++;
    if (bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'h7030) begin
      n_bad++;
      $display("FAIL clear: rdy=%b cmd=%h want 0 7030", bus.cmd_rdy, bus.cmd);
    end
    wait_neg(B);
  endtask

  task automatic test_rearm;
    send_cmd(16'h2000);
    wait_neg(B);
  endtask

  task automatic test_framing;
    send_byte(8'h70, 1'b0, 1'b0);
    rx = 1'b1;
    wait_neg(B);
    send_cmd(16'h4011);
    wait_neg(B);
  endtask

  task automatic test_overrun;
    send_cmd(16'hABCD);
    send_cmd(16'hEF01);
    wait_neg(B);
    n_cmp++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hEF01) begin
      n_bad++;
      $display("FAIL overrun: rdy=%b cmd=%h want 1 ef01", bus.cmd_rdy, bus.cmd);
    end
  endtask

  task automatic test_reset_mid_rx;
    send_byte(8'h56, 1'b1, 1'b0);
    bus.trmt = 1'b1;
    bus.resp = 8'h00;
    wait_neg(1);
    bus.trmt = 1'b0;
    rx = 1'b0;
    wait_neg(B);
    rx = 1'b1;
    wait_neg(B);
    rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
    n_cmp++;
    if ({tx, bus.cmd, bus.cmd_rdy, bus.tx_done} !== {1'b1, 16'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL mid_reset: tx=%b cmd=%h rdy=%b done=%b want 1 0000 0 0",
               tx, bus.cmd, bus.cmd_rdy, bus.tx_done);
    end
    wait_neg(2 * B);
    send_cmd(16'h1234);
    wait_neg(B);
  endtask

  task automatic test_full_duplex;
    bus.clr_cmd_rdy = 1'b1;
    wait_neg(1);
    bus.clr_cmd_rdy = 1'b0;
    fork
      send_cmd(16'h9C3E);
      begin
        wait_neg(B / 3);
        run_tx(8'h3C, 1'b0);
      end
    join
    wait_neg(B);
  endtask

  initial begin
    bus.clr_cmd_rdy = 1'b0;
    bus.trmt = 1'b0;
    bus.resp = 8'h00;
    test_reset();
    test_cmd_rx();
    test_clear();
    test_rearm();
    run_tx(8'hA5, 1'b0);
    wait_neg(B);
    run_tx(8'hA5, 1'b1);
    wait_neg(B);
    test_framing();
    test_overrun();
    test_reset_mid_rx();
    test_full_duplex();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
